// File: rtl/key_expansion_inv_128_pkg.sv
// rtl/key_expansion_inv_128_pkg.sv - shared AES constants, Rcon table and key-expansion state encoding
package key_expansion_inv_128_pkg;

    localparam int AES_NK = 4;
    localparam int AES_NR = 10;
    localparam int KEY_W  = 32 * AES_NK;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // Round constant for round r, byte in the MSB position of the word
    function automatic logic [31:0] rcon_word(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box, shared by forward and backward key expansion
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/key_expansion_inv_128.sv
// rtl/key_expansion_inv_128.sv - AES-128 backward key expansion from the round-10 key, one round per cycle
module key_expansion_inv_128
    import key_expansion_inv_128_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [3:0]   round,
    output logic [127:0] round_key_out,
    output logic         ready,
    output logic         busy
);

    state_e           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             ready_q, ready_d;
    logic [KEY_W-1:0] rk_q [AES_NR+1];
    logic [KEY_W-1:0] rk_d [AES_NR+1];

    logic [KEY_W-1:0] cur_key;
    logic [KEY_W-1:0] prev_key;
    logic [31:0]      w0, w1, w2, w3;
    logic [31:0]      p0, p1, p2, p3;
    logic [31:0]      rot_p3;
    logic [31:0]      sub_p3;

    always_comb begin
        cur_key = '0;
        for (int i = 0; i <= AES_NR; i++) begin
            if (rnd_q == 4'(i)) begin
                cur_key = rk_q[i];
            end
        end
    end

    assign {w0, w1, w2, w3} = cur_key;

    // Undo the forward word chain; only w0 needs the S-box, fed by the recovered w3
    assign p3     = w3 ^ w2;
    assign p2     = w2 ^ w1;
    assign p1     = w1 ^ w0;
    assign rot_p3 = rot_word(p3);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_p3[8*g +: 8]),
            .out_byte (sub_p3[8*g +: 8])
        );
    end

    assign p0       = w0 ^ sub_p3 ^ rcon_word(rnd_q);
    assign prev_key = {p0, p1, p2, p3};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rnd_q   <= 4'd0;
            ready_q <= 1'b0;
            for (int i = 0; i <= AES_NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            ready_q <= ready_d;
            rk_q    <= rk_d;
        end
    end

    // Start wins over an in-flight expansion so a new key restarts cleanly
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        ready_d = ready_q;
        rk_d    = rk_q;
        if (start) begin
            rk_d[AES_NR] = key_in;
            rnd_d        = 4'(AES_NR);
            ready_d      = 1'b0;
            state_d      = ST_EXPAND;
        end else if (state_q == ST_EXPAND) begin
            for (int i = 0; i < AES_NR; i++) begin
                if (rnd_q == 4'(i + 1)) begin
                    rk_d[i] = prev_key;
                end
            end
            if (rnd_q != 4'd0) begin
                rnd_d = rnd_q - 4'd1;
            end
            if (rnd_q <= 4'd1) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy          = (state_q == ST_EXPAND);
        ready         = ready_q;
        round_key_out = '0;
        for (int i = 0; i <= AES_NR; i++) begin
            if (round == 4'(i)) begin
                round_key_out = rk_q[i];
            end
        end
    end

endmodule

// File: tb/tb_key_expansion_inv_128.sv
// tb/tb_key_expansion_inv_128.sv - directed and round-trip checks for key_expansion_inv_128
module tb_key_expansion_inv_128;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   round;
    logic [127:0] round_key_out;
    logic         ready;
    logic         busy;

    int n_assert;
    int n_fail;

    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [7:0]   sbm [256];
    logic [127:0] exp_rk [11];

    key_expansion_inv_128 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .key_in        (key_in),
        .round         (round),
        .round_key_out (round_key_out),
        .ready         (ready),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from GF(2^8) inverse plus affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbm[a] = s;
        end
    endtask

    task automatic expand_fwd(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = key;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic run_and_check_latency(input string tag, input logic [127:0] k10);
        key_in = k10;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({tag, "_busy_after_start"}, 128'(busy), 128'(1));
        repeat (9) tick();
        check({tag, "_ready_edge9"}, 128'(ready), 128'(0));
        tick();
        check({tag, "_ready_edge10"}, 128'(ready), 128'(1));
        check({tag, "_busy_edge10"}, 128'(busy), 128'(0));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        round    = 4'd0;
        build_sbox();
        tick();
        tick();
        check("reset_ready", 128'(ready), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        round = 4'd10;
        #1;
        check("reset_rk10", round_key_out, 128'h0);
        rst_n = 1'b1;
        tick();

        run_and_check_latency("fips", FIPS_RK[10]);
        for (int r = 0; r < 11; r++) begin
            round = 4'(r);
            #1;
            check($sformatf("fips_rk%0d", r), round_key_out, FIPS_RK[r]);
        end
        round = 4'd11;
        #1;
        check("round11_zero", round_key_out, 128'h0);
        round = 4'd15;
        #1;
        check("round15_zero", round_key_out, 128'h0);

        repeat (5) tick();
        round = 4'd5;
        #1;
        check("idle_hold_rk5", round_key_out, FIPS_RK[5]);
        check("idle_hold_ready", 128'(ready), 128'(1));

        key_in = '0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("restart_ready_clr", 128'(ready), 128'(0));
        repeat (3) tick();
        run_and_check_latency("restart", FIPS_RK[10]);
        for (int r = 0; r < 11; r++) begin
            round = 4'(r);
            #1;
            check($sformatf("restart_rk%0d", r), round_key_out, FIPS_RK[r]);
        end

        key_in = FIPS_RK[10];
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_ready", 128'(ready), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        for (int r = 0; r < 11; r++) begin
            round = 4'(r);
            #1;
            check($sformatf("midrst_rk%0d", r), round_key_out, 128'h0);
        end
        tick();
        check("midrst_ready_later", 128'(ready), 128'(0));

        rst_n  = 1'b0;
        start  = 1'b1;
        key_in = FIPS_RK[10];
        tick();
        rst_n  = 1'b1;
        start  = 1'b0;
        check("rst_prio_busy", 128'(busy), 128'(0));
        round = 4'd10;
        #1;
        check("rst_prio_rk10", round_key_out, 128'h0);

        for (int n = 0; n < 100; n++) begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            expand_fwd(k);
            key_in = exp_rk[10];
            start  = 1'b1;
            tick();
            start  = 1'b0;
            repeat (10) tick();
            check($sformatf("rt%0d_ready", n), 128'(ready), 128'(1));
            for (int r = 0; r < 11; r++) begin
                round = 4'(r);
                #1;
                check($sformatf("rt%0d_rk%0d", n, r), round_key_out, exp_rk[r]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
